weight_buffer_loader: RTL

- Write-side producer for the 512-bit weight buffer.
- Accepts a valid/ready stream of 32-bit fp32 weight words from the DMA or host side.
- Packs each group of LANES words into one 512-bit line and issues one single-cycle write per line on the buffer's CEN/WEN/A/D port.
- Writes `num_lines` consecutive lines starting at `base_addr`, then pulses `done`.

---
 rtl/weight_buffer_loader_if.sv | 26 ++
 rtl/weight_buffer_loader.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/weight_buffer_loader_if.sv
// Stream-in and buffer write-port bundle for the weight buffer loader.
// The loader takes the master side; the environment (source and buffer) takes the slave side.
interface weight_buffer_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 16,
  parameter int unsigned ADDR_W = 13
);
  logic                      s_valid;
  logic [DATA_W-1:0]         s_data;
  logic                      s_ready;
  logic                      buf_cen;
  logic                      buf_wen;
  logic [ADDR_W-1:0]         buf_a;
  logic [DATA_W*LANES-1:0]   buf_d;
  logic                      buf_retn;

  modport master (
    input  s_valid, s_data,
    output s_ready, buf_cen, buf_wen, buf_a, buf_d, buf_retn
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, buf_cen, buf_wen, buf_a, buf_d, buf_retn
  );
endinterface

// File: rtl/weight_buffer_loader.sv
// Packs LANES stream words into one buffer line and issues a single-cycle write per line,
// for num_lines consecutive (DEPTH-wrapping) addresses starting at base_addr.
module weight_buffer_loader #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 16,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [ADDR_W-1:0]      num_lines,
  weight_buffer_loader_if.master wb,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_e;

  state_e                        state_q, state_d;
  logic [LW-1:0]                 lane_cnt_q, lane_cnt_d;
  logic [ADDR_W-1:0]             line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0]             base_q, base_d;
  logic [ADDR_W-1:0]             num_q, num_d;
  logic [LANES-1:0][DATA_W-1:0]  line_q, line_d;

  logic                          s_ready_q, s_ready_d;
  logic                          cen_q, cen_d;
  logic                          wen_q, wen_d;
  logic [ADDR_W-1:0]             a_q, a_d;
  logic [DATA_W*LANES-1:0]       d_q, d_d;
  logic                          retn_q, retn_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [ADDR_W-1:0]             line_addr;

  assign line_addr = (base_q + line_cnt_q) & ADDR_W'(DEPTH - 1);

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    line_cnt_d = line_cnt_q;
    base_d     = base_q;
    num_d      = num_q;
    line_d     = line_q;
    a_d        = a_q;
    d_d        = d_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d     = base_addr;
          num_d      = num_lines;
          lane_cnt_d = '0;
          line_cnt_d = '0;
          state_d    = (num_lines == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (abort) begin
          state_d    = IDLE;
          lane_cnt_d = '0;
          line_cnt_d = '0;
        end else if (wb.s_valid && s_ready_q) begin
          line_d[lane_cnt_q] = wb.s_data;
          lane_cnt_d         = lane_cnt_q + 1'b1;
          if (lane_cnt_q == LW'(LANES - 1)) state_d = WRITE;
        end
      end
      WRITE: begin
        lane_cnt_d = '0;
        if (abort) begin
          state_d    = IDLE;
          line_cnt_d = '0;
        end else begin
          line_cnt_d = line_cnt_q + 1'b1;
          state_d    = (line_cnt_d == num_q) ? DONE : FILL;
        end
      end
      DONE: begin
        state_d    = IDLE;
        lane_cnt_d = '0;
        line_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state, so the write strobes line up with WRITE
    // and the last word accepted this cycle is already part of the captured line.
    if (state_q == FILL && state_d == WRITE) begin
      a_d = line_addr;
      d_d = line_d;
    end

    s_ready_d = (state_d == FILL);
    cen_d     = (state_d != WRITE);
    wen_d     = (state_d != WRITE);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    retn_d    = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      line_cnt_q <= '0;
      base_q     <= '0;
      num_q      <= '0;
      line_q     <= '0;
      s_ready_q  <= 1'b0;
      cen_q      <= 1'b1;
      wen_q      <= 1'b1;
      a_q        <= '0;
      d_q        <= '0;
      retn_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      line_cnt_q <= line_cnt_d;
      base_q     <= base_d;
      num_q      <= num_d;
      line_q     <= line_d;
      s_ready_q  <= s_ready_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      a_q        <= a_d;
      d_q        <= d_d;
      retn_q     <= retn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign wb.s_ready  = s_ready_q;
  assign wb.buf_cen  = cen_q;
  assign wb.buf_wen  = wen_q;
  assign wb.buf_a    = a_q;
  assign wb.buf_d    = d_q;
  assign wb.buf_retn = retn_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
